// File: rtl/waiz_input_loader_pkg.sv
// Shared types and fixed-point helpers for the waiz input path.
package waiz_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } loader_state_t;

    // Round half up by sh fractional bits, then saturate to a signed width-bit range.
    function automatic logic signed [63:0] fx_round_sat(
        input logic signed [63:0] x,
        input int                 sh,
        input int                 width
    );
        logic signed [63:0] t;
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        t = x;
        if (sh > 0) begin
            t = x + (64'sd1 <<< (sh - 1));
        end
        r     = t >>> sh;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/waiz_input_loader_fx_convert.sv
// Combinational Q(IN_WIDTH,IN_NFRAC) -> Q(WIDTH,NFRAC) conversion with round half up and saturation.
module waiz_fx_convert
    import waiz_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NFRAC    = 10,
    parameter int IN_WIDTH = 24,
    parameter int IN_NFRAC = 16
) (
    input  logic signed [IN_WIDTH-1:0] i_data,
    output logic signed [WIDTH-1:0]    o_data
);

    if (IN_NFRAC < NFRAC) begin : g_bad_frac
        $error("waiz_fx_convert: IN_NFRAC must be >= NFRAC");
    end

    assign o_data = WIDTH'(fx_round_sat(64'(i_data), IN_NFRAC - NFRAC, WIDTH));

endmodule

// File: rtl/waiz_input_loader.sv
// Stream-to-frame loader: converts incoming beats and presents a stable feature frame to waiz_benchmark.
module waiz_input_loader
    import waiz_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NFRAC      = 10,
    parameter int IN_WIDTH   = 24,
    parameter int IN_NFRAC   = 16,
    parameter int INPUT_SIZE = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [IN_WIDTH-1:0] s_data,
    input  logic                       s_last,
    output logic                       input_ready,
    output logic signed [WIDTH-1:0]    input_data [0:INPUT_SIZE-1],
    input  logic                       output_ready,
    output logic                       frame_err,
    output logic [15:0]                frame_count
);

    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

    loader_state_t           r_state;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_or_q;
    logic signed [WIDTH-1:0] w_conv;
    logic                    w_beat;
    logic                    w_at_last;
    logic                    w_done;

    waiz_fx_convert #(
        .WIDTH    (WIDTH),
        .NFRAC    (NFRAC),
        .IN_WIDTH (IN_WIDTH),
        .IN_NFRAC (IN_NFRAC)
    ) u_conv (
        .i_data (s_data),
        .o_data (w_conv)
    );

    assign w_beat    = s_valid && s_ready;
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_done    = output_ready && !r_or_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FILL;
            r_idx       <= '0;
            r_or_q      <= 1'b0;
            s_ready     <= 1'b0;
            input_ready <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 16'd0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                input_data[i] <= '0;
            end
        end else begin
            r_or_q      <= output_ready;
            input_ready <= 1'b0;
            frame_err   <= 1'b0;
            case (r_state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (w_beat) begin
                        input_data[r_idx] <= w_conv;
                        if (w_at_last && s_last) begin
                            // Launch outputs are registered so they are visible during the LAUNCH cycle.
                            r_idx       <= '0;
                            s_ready     <= 1'b0;
                            input_ready <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            r_state     <= LAUNCH;
                        end else if (!w_at_last && !s_last) begin
                            r_idx <= r_idx + 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            r_idx     <= '0;
                        end
                    end
                end
                LAUNCH: begin
                    s_ready <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    s_ready <= 1'b0;
                    if (w_done) begin
                        s_ready <= 1'b1;
                        r_state <= FILL;
                    end
                end
                default: begin
                    s_ready <= 1'b0;
                    r_idx   <= '0;
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_waiz_input_loader.sv
// Directed and randomized bench for waiz_input_loader against an arithmetic reference model.
module tb_waiz_input_loader;

    logic                clk;
    logic                reset;
    logic                s_valid;
    logic                s_ready;
    logic signed [23:0]  s_data;
    logic                s_last;
    logic                input_ready;
    logic signed [15:0]  input_data [0:15];
    logic                output_ready;
    logic                frame_err;
    logic [15:0]         frame_count;

    int n_tests;
    int n_fail;
    int cur [16];
    int exp_data [16];
    int exp_count;

    waiz_input_loader dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_ready (output_ready),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value / 64 rounded to nearest with ties toward +inf, clamped to 16-bit signed.
    function automatic int ref_conv(input int x);
        int t;
        int r;
        t = x + 32;
        if (t >= 0) r = t / 64;
        else        r = -((-t + 63) / 64);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input bit last);
        int cnt;
        s_valid = 1'b1;
        s_data  = 24'(d);
        s_last  = last;
        cnt     = 0;
        while (!s_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) chk("s_ready_timeout", longint'(s_ready), 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_data(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_data%0d", tag, i), longint'(input_data[i]), longint'(exp_data[i]));
        end
    endtask

    task automatic do_frame(input string tag);
        for (int i = 0; i < 16; i++) begin
            send(cur[i], i == 15);
            exp_data[i] = ref_conv(cur[i]);
        end
        exp_count = (exp_count + 1) & 16'hFFFF;
        chk({tag, "_input_ready"}, longint'(input_ready), 1);
        chk({tag, "_frame_count"}, longint'(frame_count), longint'(exp_count));
        chk({tag, "_s_ready_low"}, longint'(s_ready), 0);
        @(negedge clk);
        chk({tag, "_input_ready_pulse"}, longint'(input_ready), 0);
        check_data(tag);
    endtask

    task automatic complete(input string tag);
        output_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_s_ready_after_done"}, longint'(s_ready), 1);
        output_ready = 1'b0;
    endtask

    task automatic rand_frame();
        logic signed [23:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 24'($urandom);
            if (($urandom & 3) == 0) v = v >>> 8;
            cur[i] = int'(v);
        end
    endtask

    initial begin
        int base [16];
        n_tests      = 0;
        n_fail       = 0;
        exp_count    = 0;
        s_valid      = 1'b0;
        s_data       = '0;
        s_last       = 1'b0;
        output_ready = 1'b0;
        reset        = 1'b1;
        base = '{-304, 378, 253, -8, 123, 14, -399, -144, -399, -629, -664, -537, -586, -376, 284, 430};

        // 1. reset behaviour
        repeat (2) @(negedge clk);
        chk("rst_s_ready", longint'(s_ready), 0);
        chk("rst_input_ready", longint'(input_ready), 0);
        chk("rst_frame_err", longint'(frame_err), 0);
        chk("rst_frame_count", longint'(frame_count), 0);
        chk("rst_data0", longint'(input_data[0]), 0);
        reset = 1'b0;
        #1;
        chk("rel_s_ready_before_edge", longint'(s_ready), 0);
        @(negedge clk);
        chk("rel_s_ready_after_edge", longint'(s_ready), 1);

        // 2. reference frame
        for (int i = 0; i < 16; i++) cur[i] = base[i] * 64;
        do_frame("frame_list");
        for (int i = 0; i < 16; i++) chk($sformatf("list_exact%0d", i), longint'(input_data[i]), longint'(base[i]));
        repeat (3) begin
            @(negedge clk);
            chk("wait_s_ready", longint'(s_ready), 0);
        end
        complete("list");

        // 3. conversion corners plus random fill
        rand_frame();
        cur[0] = 32; cur[1] = -32; cur[2] = 31; cur[3] = 8388607; cur[4] = -8388608;
        do_frame("corners");
        chk("corner_32", longint'(input_data[0]), 1);
        chk("corner_m32", longint'(input_data[1]), 0);
        chk("corner_31", longint'(input_data[2]), 0);
        chk("corner_max", longint'(input_data[3]), 32767);
        chk("corner_min", longint'(input_data[4]), -32768);
        complete("corners");

        // 4. early s_last
        for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 4000)), i == 4);
        chk("early_last_err", longint'(frame_err), 1);
        chk("early_last_no_launch", longint'(input_ready), 0);
        @(negedge clk);
        chk("early_last_err_pulse", longint'(frame_err), 0);
        chk("early_last_fill", longint'(s_ready), 1);
        rand_frame();
        do_frame("after_err");
        complete("after_err");

        // 4b. missing s_last on the final beat
        for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 4000)), 1'b0);
        chk("missing_last_err", longint'(frame_err), 1);
        chk("missing_last_no_launch", longint'(input_ready), 0);
        chk("missing_last_count", longint'(frame_count), longint'(exp_count));

        // 5. output_ready held high across frames
        rand_frame();
        do_frame("held_a");
        output_ready = 1'b1;
        @(negedge clk);
        chk("held_a_done", longint'(s_ready), 1);
        rand_frame();
        do_frame("held_b");
        s_valid = 1'b1;
        s_data  = 24'sd12345;
        s_last  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("held_level_no_done", longint'(s_ready), 0);
        end
        check_data("held_frozen");
        s_valid = 1'b0;
        s_last  = 1'b0;
        output_ready = 1'b0;
        @(negedge clk);
        chk("held_low_still_wait", longint'(s_ready), 0);
        complete("held_b");

        // 6. reset mid-fill and mid-wait
        for (int i = 0; i < 8; i++) send(int'($urandom_range(64, 9000)), 1'b0);
        reset = 1'b1;
        #1;
        chk("midfill_rst_data0", longint'(input_data[0]), 0);
        chk("midfill_rst_s_ready", longint'(s_ready), 0);
        chk("midfill_rst_count", longint'(frame_count), 0);
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midfill_no_err", longint'(frame_err), 0);
        rand_frame();
        do_frame("post_rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("wait_rst_count", longint'(frame_count), 0);
        chk("wait_rst_data3", longint'(input_data[3]), 0);
        chk("wait_rst_input_ready", longint'(input_ready), 0);
        exp_count = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rand_frame();
        do_frame("post_wait_rst");
        complete("post_wait_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
